// File: rtl/code_sweep.sv
// rtl/code_sweep.sv - stride sweep controller driving the ten detector code input and tallying P hits
// Optional abort input enabled by defining CODE_SWEEP_ABORT_EN.
module code_sweep #(
  parameter int WIDTH  = 5,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [WIDTH-1:0] stride,
  input  logic             p_in,
`ifdef CODE_SWEEP_ABORT_EN
  input  logic             abort,
`endif
  output logic [WIDTH-1:0] code,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   hits,
  output logic [WIDTH-1:0] first_hit,
  output logic             hit_valid
);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_SAMPLE, S_DONE} state_t;

  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH:0]   HITS_MAX = {1'b1, {WIDTH{1'b0}}};
  // HOLD lasts SETTLE cycles, so the counter is loaded one short; SETTLE=0 skips HOLD entirely.
  localparam logic [3:0]       RELOAD   = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;
  localparam state_t           LOAD_ST  = (SETTLE > 0) ? S_HOLD : S_SAMPLE;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] code_q, code_d;
  logic [WIDTH-1:0] stride_q, stride_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH:0]   hits_q, hits_d;
  logic [WIDTH-1:0] first_q, first_d;
  logic             hv_q, hv_d;
  logic [WIDTH:0]   sum;
  logic             abort_w;

`ifdef CODE_SWEEP_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      code_q   <= '0;
      stride_q <= ONE;
      cnt_q    <= '0;
      hits_q   <= '0;
      first_q  <= '0;
      hv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      stride_q <= stride_d;
      cnt_q    <= cnt_d;
      hits_q   <= hits_d;
      first_q  <= first_d;
      hv_q     <= hv_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    stride_d = stride_q;
    cnt_d    = cnt_q;
    hits_d   = hits_q;
    first_d  = first_q;
    hv_d     = hv_q;
    sum      = {1'b0, code_q} + {1'b0, stride_q};
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          stride_d = (stride == '0) ? ONE : stride;
          hits_d   = '0;
          first_d  = '0;
          hv_d     = 1'b0;
          code_d   = '0;
          cnt_d    = RELOAD;
          state_d  = LOAD_ST;
        end
      end
      S_HOLD: begin
        if (abort_w)             state_d = S_IDLE;
        else if (cnt_q != 4'd0)  cnt_d   = cnt_q - 4'd1;
        else                     state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        if (abort_w) begin
          state_d = S_IDLE;
        end else begin
          if (p_in) begin
            if (hits_q != HITS_MAX) hits_d = hits_q + 1'b1;
            if (!hv_q) begin
              first_d = code_q;
              hv_d    = 1'b1;
            end
          end
          // The carry bit means the next step would pass the top code: finish instead of wrapping.
          if (!sum[WIDTH]) begin
            code_d  = sum[WIDTH-1:0];
            cnt_d   = RELOAD;
            state_d = LOAD_ST;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign code      = code_q;
  assign busy      = (state_q == S_HOLD) || (state_q == S_SAMPLE);
  assign done      = (state_q == S_DONE);
  assign hits      = hits_q;
  assign first_hit = first_q;
  assign hit_valid = hv_q;

endmodule

// File: tb/tb_code_sweep.sv
// tb/tb_code_sweep.sv - randomized self-checking bench for code_sweep against a per-cycle sweep model
// Abort scenario is exercised only when CODE_SWEEP_ABORT_EN is defined.
module tb_code_sweep;
  localparam int W = 5;
  localparam int S = 1;
  localparam int TOP = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] stride = '0;
  logic         p_in;
  logic [W-1:0] code;
  logic         busy, done, hit_valid;
  logic [W:0]   hits;
  logic [W-1:0] first_hit;
`ifdef CODE_SWEEP_ABORT_EN
  logic         abort = 1'b0;
`else
  logic         abort;
  assign abort = 1'b0;
`endif

  int           mode = 0;
  logic [31:0]  mask = '0;
  int           n_checks = 0, n_fail = 0;
  int           busy_cnt = 0, done_cnt = 0;
  bit           chk_en = 0;

  int           m_t = 0, m_last = 0, m_s = 1, m_mode = 0;
  logic [31:0]  m_mask = '0;

  typedef struct {
    int code; bit busy; bit done; int hits; int first; bit hv;
  } exp_t;

  code_sweep #(.WIDTH(W), .SETTLE(S)) dut (
    .clk(clk), .rstn(rstn), .start(start), .stride(stride), .p_in(p_in),
`ifdef CODE_SWEEP_ABORT_EN
    .abort(abort),
`endif
    .code(code), .busy(busy), .done(done), .hits(hits),
    .first_hit(first_hit), .hit_valid(hit_valid)
  );

  always #5 clk = ~clk;

  // Stand-in for the ten detector, combinational on the driven code.
  assign p_in = (mode == 0) ? (code == 5'd10) :
                (mode == 1) ? 1'b1 :
                (mode == 2) ? (code >= 5'd4) : mask[code];

  function automatic bit model_hit(input int c);
    case (m_mode)
      0:       return c == 10;
      1:       return 1'b1;
      2:       return c >= 4;
      default: return m_mask[c];
    endcase
  endfunction

  function automatic int n_codes(input int s);
    return TOP / s + 1;
  endfunction

  // Expected outputs t cycles after start acceptance (t=0 means nothing accepted since reset).
  function automatic exp_t exp_at(input int t, input int s);
    exp_t e;
    int n, idx;
    e = '{0, 0, 0, 0, 0, 0};
    if (t == 0) return e;
    n   = n_codes(s);
    idx = (t - 1) / (S + 1);
    if (idx > n - 1) idx = n - 1;
    e.code = idx * s;
    e.busy = (t <= n * (S + 1));
    e.done = (t == n * (S + 1) + 1);
    for (int i = 0; i < n; i++) begin
      if ((i + 1) * (S + 1) < t && model_hit(i * s)) begin
        if (!e.hv) begin e.first = i * s; e.hv = 1; end
        if (e.hits < (1 << W)) e.hits++;
      end
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (rstn) begin
      if (m_t == 0) begin
        if (start) begin
          m_s    = (stride == 0) ? 1 : int'(stride);
          m_mode = mode;
          m_mask = mask;
          m_t    = 1;
        end
      end else if (abort && m_t <= n_codes(m_s) * (S + 1)) begin
        m_last = m_t;
        m_t    = 0;
      end else if (m_t == n_codes(m_s) * (S + 1) + 1) begin
        m_last = m_t;
        m_t    = 0;
      end else begin
        m_t++;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (chk_en) begin
      if (m_t == 0) begin
        e = exp_at(m_last, m_s);
        e.busy = 0;
        e.done = 0;
      end else begin
        e = exp_at(m_t, m_s);
      end
      chk("code", 32'(code), 32'(e.code));
      chk("busy", 32'(busy), 32'(e.busy));
      chk("done", 32'(done), 32'(e.done));
      chk("hits", 32'(hits), 32'(e.hits));
      chk("first_hit", 32'(first_hit), 32'(e.first));
      chk("hit_valid", 32'(hit_valid), 32'(e.hv));
      if (busy) busy_cnt++;
      if (done) done_cnt++;
    end
  end

  task automatic run_sweep(input int s, input int md, input int restart_at, input bit start_in_done);
    mode = md;
    @(negedge clk); #1;
    busy_cnt = 0;
    done_cnt = 0;
    stride = W'(s);
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    for (int cyc = 1; cyc <= 500; cyc++) begin
      if (done_cnt > 0) break;
      start  = (cyc == restart_at);
      stride = W'($urandom);
      @(negedge clk); #1;
    end
    if (done_cnt == 0) chk("done_timeout", 0, 1);
    start = start_in_done;
    @(negedge clk); #1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    #1;
  endtask

  initial begin
    int waited;
    repeat (2) @(posedge clk);
    #1 chk_en = 1;
    @(posedge clk); #2 rstn = 1'b1;
    repeat (10) @(negedge clk);
    chk("rst_code", 32'(code), 0);
    chk("rst_hits", 32'(hits), 0);
    chk("rst_busy", 32'(busy), 0);

    run_sweep(1, 0, 0, 0);
    chk("eq10_busy_cycles", busy_cnt, 64);
    chk("eq10_done_cnt", done_cnt, 1);
    chk("eq10_hits", 32'(hits), 1);
    chk("eq10_first", 32'(first_hit), 10);
    chk("eq10_hv", 32'(hit_valid), 1);
    chk("eq10_last_code", 32'(code), 31);

    run_sweep(7, 1, 0, 0);
    chk("s7_busy_cycles", busy_cnt, 10);
    chk("s7_hits", 32'(hits), 5);
    chk("s7_first", 32'(first_hit), 0);
    chk("s7_last_code", 32'(code), 28);

    run_sweep(0, 0, 5, 1);
    chk("s0_busy_cycles", busy_cnt, 64);
    chk("s0_done_cnt", done_cnt, 1);
    chk("s0_hits", 32'(hits), 1);

    run_sweep(1, 1, 0, 0);
    chk("sat_hits", 32'(hits), 32);

    mode = 0;
    @(negedge clk); #1;
    stride = 5'd3;
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    waited = 0;
    while (code != 5'd12 && waited < 200) begin
      @(negedge clk); #1;
      waited++;
    end
    if (code != 5'd12) chk("reach_code12_timeout", 0, 1);
    @(posedge clk); #2;
    rstn = 1'b0;
    m_t = 0;
    m_last = 0;
    #1;
    chk("async_rst_code", 32'(code), 0);
    chk("async_rst_busy", 32'(busy), 0);
    chk("async_rst_hits", 32'(hits), 0);
    @(posedge clk); #2 rstn = 1'b1;
    run_sweep(3, 2, 0, 0);
    chk("post_rst_busy_cycles", busy_cnt, 22);
    chk("post_rst_hits", 32'(hits), 9);
    chk("post_rst_first", 32'(first_hit), 6);

`ifdef CODE_SWEEP_ABORT_EN
    mode = 2;
    @(negedge clk); #1;
    busy_cnt = 0;
    done_cnt = 0;
    stride = 5'd1;
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    waited = 0;
    while (m_t != 13 && waited < 200) begin
      @(negedge clk); #1;
      waited++;
    end
    if (m_t != 13) chk("abort_point_timeout", 0, 1);
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk); #1;
    abort = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("abort_done_cnt", done_cnt, 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_hits", 32'(hits), 2);
    chk("abort_first", 32'(first_hit), 4);
    chk("abort_code", 32'(code), 6);
`endif

    for (int k = 0; k < 8; k++) begin
      mask = $urandom;
      run_sweep(int'($urandom_range(0, 31)), 3, int'($urandom_range(0, 12)), bit'($urandom_range(0, 1)));
      chk("rand_done_cnt", done_cnt, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout at %0t: got 0 expected 1", $time);
    $fatal(1, "timeout");
  end
endmodule
